// File: rtl/alu_sequencer.sv
// Fetch/execute sequencer for the 4-bit processor: owns PC, IR, ACC and C/Z flags,
// and drives an external combinational ALU.
module alu_sequencer #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [11:0] prog_addr,
  input  logic [7:0]  prog_data,
  output logic [2:0]  alu_sel,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  input  logic [3:0]  alu_y,
  input  logic        alu_c,
  input  logic        alu_z,
  output logic [3:0]  acc,
  output logic        flag_c,
  output logic        flag_z,
  output logic [3:0]  out_data,
  output logic        out_valid,
  output logic        halted
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_EXEC   = 2'd1;
  localparam logic [1:0] S_OPLOAD = 2'd2;
  localparam logic [1:0] S_HALT   = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_NAND = 4'h4;
  localparam logic [3:0] OP_CMP  = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JC   = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hA;

  localparam logic [2:0] SEL_PASSA = 3'b000;
  localparam logic [2:0] SEL_SUB   = 3'b001;
  localparam logic [2:0] SEL_PASSB = 3'b010;
  localparam logic [2:0] SEL_ADD   = 3'b011;
  localparam logic [2:0] SEL_NAND  = 3'b100;

  logic [1:0]  state;
  logic [11:0] pc;
  logic [7:0]  ir;
  logic [3:0]  opcode;
  logic        jump_taken;
  logic        is_jump;
  logic        writes_acc;

  function automatic logic [2:0] decode_sel(input logic [3:0] op);
    logic [2:0] sel;
    case (op)
      OP_LIT:         sel = SEL_PASSB;
      OP_ADD:         sel = SEL_ADD;
      OP_SUB, OP_CMP: sel = SEL_SUB;
      OP_NAND:        sel = SEL_NAND;
      default:        sel = SEL_PASSA;
    endcase
    return sel;
  endfunction

  assign opcode     = ir[7:4];
  assign prog_addr  = pc;
  assign alu_a      = acc;
  assign alu_b      = ir[3:0];
  assign halted     = (state == S_HALT);
  assign is_jump    = (opcode == OP_JMP) || (opcode == OP_JC) || (opcode == OP_JZ);
  assign writes_acc = (opcode == OP_LIT) || (opcode == OP_ADD) ||
                      (opcode == OP_SUB) || (opcode == OP_NAND);

  // The ALU sees a real selector only while an instruction is executing.
  always_comb begin
    alu_sel = SEL_PASSA;
    if (state == S_EXEC) alu_sel = decode_sel(opcode);
  end

  always_comb begin
    case (opcode)
      OP_JMP:  jump_taken = 1'b1;
      OP_JC:   jump_taken = flag_c;
      OP_JZ:   jump_taken = flag_z;
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= 8'h00;
      acc       <= 4'h0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      out_data  <= 4'h0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (enable) begin
            ir    <= prog_data;
            pc    <= pc + 12'd1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (writes_acc) begin
            acc    <= alu_y;
            flag_c <= alu_c;
            flag_z <= alu_z;
          end else if (opcode == OP_CMP) begin
            flag_c <= alu_c;
            flag_z <= alu_z;
          end else if (opcode == OP_OUT) begin
            out_data  <= acc;
            out_valid <= 1'b1;
          end
          if (is_jump)                state <= S_OPLOAD;
          else if (opcode == OP_HALT) state <= S_HALT;
          else                        state <= S_FETCH;
        end
        // PC already points at the address byte; a skipped jump steps over it.
        S_OPLOAD: begin
          if (jump_taken) pc <= {ir[3:0], prog_data};
          else            pc <= pc + 12'd1;
          state <= S_FETCH;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: two instances (RESET_PC 0x000 and 0xFFF),
// each with its own program memory and combinational ALU model.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst1, rst2, en1, en2;
  logic [11:0] pa1, pa2;
  logic [7:0]  pd1, pd2;
  logic [2:0]  sel1, sel2;
  logic [3:0]  a1, b1, y1, a2, b2, y2;
  logic        c1, z1, c2, z2;
  logic [3:0]  acc1, acc2, od1, od2;
  logic        fc1, fz1, fc2, fz2, ov1, ov2, h1, h2;

  logic [7:0] mem1 [0:4095];
  logic [7:0] mem2 [0:4095];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] r;
    case (s)
      3'b001:  r = {1'b0, a} - {1'b0, b};
      3'b010:  r = {1'b0, b};
      3'b011:  r = {1'b0, a} + {1'b0, b};
      3'b100:  r = {1'b0, ~(a & b)};
      default: r = {1'b0, a};
    endcase
    return {r[4], (r[3:0] == 4'h0), r[3:0]};
  endfunction

  assign pd1 = mem1[pa1];
  assign pd2 = mem2[pa2];
  assign {c1, z1, y1} = alu_f(sel1, a1, b1);
  assign {c2, z2, y2} = alu_f(sel2, a2, b2);

  alu_sequencer #(.RESET_PC(12'h000)) dut1 (
    .clk(clk), .reset(rst1), .enable(en1), .prog_addr(pa1), .prog_data(pd1),
    .alu_sel(sel1), .alu_a(a1), .alu_b(b1), .alu_y(y1), .alu_c(c1), .alu_z(z1),
    .acc(acc1), .flag_c(fc1), .flag_z(fz1), .out_data(od1), .out_valid(ov1), .halted(h1)
  );

  alu_sequencer #(.RESET_PC(12'hFFF)) dut2 (
    .clk(clk), .reset(rst2), .enable(en2), .prog_addr(pa2), .prog_data(pd2),
    .alu_sel(sel2), .alu_a(a2), .alu_b(b2), .alu_y(y2), .alu_c(c2), .alu_z(z2),
    .acc(acc2), .flag_c(fc2), .flag_z(fz2), .out_data(od2), .out_valid(ov2), .halted(h2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem1();
    for (int i = 0; i < 4096; i++) mem1[i] = 8'h00;
  endtask

  // Hold reset over one edge, then release just after it.
  task automatic restart1();
    rst1 = 1'b1;
    step(1);
    rst1 = 1'b0;
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    clear_mem1();
    for (int i = 0; i < 4096; i++) mem2[i] = 8'h00;

    // Reset state
    step(1);
    check("rst_pc", pa1, 12'h000);
    check("rst_acc", acc1, 4'h0);
    check("rst_flags", {fc1, fz1}, 2'b00);
    check("rst_out", {od1, ov1, h1}, 6'h00);
    check("rst_sel", sel1, 3'b000);

    // LIT 9; ADD 8; HALT
    mem1[0] = 8'h19; mem1[1] = 8'h28; mem1[2] = 8'hA0;
    restart1();
    step(1);
    check("t1_exec_sel", sel1, 3'b010);
    check("t1_pc_after_fetch", pa1, 12'h001);
    step(1);
    check("t1_lit_acc", acc1, 4'h9);
    step(2);
    check("t1_add_acc", acc1, 4'h1);
    check("t1_add_c", fc1, 1'b1);
    check("t1_add_z", fz1, 1'b0);
    step(1);
    check("t1_not_halted_yet", h1, 1'b0);
    step(1);
    check("t1_halted", h1, 1'b1);
    step(3);
    check("t1_halt_hold", h1, 1'b1);
    check("t1_pc_frozen", pa1, 12'h003);
    check("t1_halt_sel", sel1, 3'b000);

    // LIT 3; SUB 3; CMP 4
    clear_mem1();
    mem1[0] = 8'h13; mem1[1] = 8'h33; mem1[2] = 8'h54; mem1[3] = 8'hA0;
    restart1();
    step(4);
    check("t2_sub_acc", acc1, 4'h0);
    check("t2_sub_z", fz1, 1'b1);
    check("t2_sub_c", fc1, 1'b0);
    step(2);
    check("t2_cmp_c", fc1, 1'b1);
    check("t2_cmp_z", fz1, 1'b0);
    check("t2_cmp_acc", acc1, 4'h0);

    // LIT 0; JZ 0x123 (taken); OUT at 0x123
    clear_mem1();
    mem1[0] = 8'h10; mem1[1] = 8'h91; mem1[2] = 8'h23; mem1[3] = 8'hA0;
    mem1[12'h123] = 8'h60; mem1[12'h124] = 8'hA0;
    restart1();
    step(4);
    check("t3_oplod_sel", sel1, 3'b000);
    check("t3_jz_pc_before", pa1, 12'h002);
    step(1);
    check("t3_jz_taken_pc", pa1, 12'h123);
    check("t3_flags_kept", {fc1, fz1}, 2'b01);
    step(2);
    check("t3_out_valid", ov1, 1'b1);
    check("t3_out_data", od1, 4'h0);

    // Same with LIT 1: JZ not taken, address byte skipped
    mem1[0] = 8'h11;
    restart1();
    step(5);
    check("t3_jz_skip_pc", pa1, 12'h003);
    step(1);
    check("t3_next_fetch_pc", pa1, 12'h004);
    step(1);
    check("t3_skip_halted", h1, 1'b1);
    check("t3_skip_acc", acc1, 4'h1);

    // LIT 5; OUT; OUT; stall; HALT
    clear_mem1();
    mem1[0] = 8'h15; mem1[1] = 8'h60; mem1[2] = 8'h60; mem1[3] = 8'hA0;
    restart1();
    step(3);
    check("t4_pre_valid", ov1, 1'b0);
    step(1);
    check("t4_out1_valid", ov1, 1'b1);
    check("t4_out1_data", od1, 4'h5);
    step(1);
    check("t4_gap_valid", ov1, 1'b0);
    step(1);
    check("t4_out2_valid", ov1, 1'b1);
    en1 = 1'b0;
    step(1);
    check("t4_post_valid", ov1, 1'b0);
    step(2);
    check("t4_stall_pc", pa1, 12'h003);
    check("t4_stall_acc", acc1, 4'h5);
    check("t4_stall_halted", h1, 1'b0);
    en1 = 1'b1;
    step(1);
    check("t4_resume_pc", pa1, 12'h004);
    step(1);
    check("t4_halted", h1, 1'b1);

    // RESET_PC 0xFFF: LIT 7 then wrap to 0x000
    mem2[12'hFFF] = 8'h17; mem2[12'h000] = 8'hA0;
    step(1);
    check("t5_rst_pc", pa2, 12'hFFF);
    rst2 = 1'b0;
    step(1);
    check("t5_wrap_pc", pa2, 12'h000);
    step(1);
    check("t5_acc", acc2, 4'h7);
    step(2);
    check("t5_halted", h2, 1'b1);
    check("t5_pc_after", pa2, 12'h001);

    // LIT 3; CMP 4; JMP 0x050 -- reset lands during OPLOAD
    clear_mem1();
    mem1[0] = 8'h13; mem1[1] = 8'h54; mem1[2] = 8'h70; mem1[3] = 8'h50;
    restart1();
    step(6);
    check("t6_pre_acc", acc1, 4'h3);
    check("t6_pre_c", fc1, 1'b1);
    check("t6_pre_pc", pa1, 12'h003);
    rst1 = 1'b1;
    #1;
    check("t6_async_pc", pa1, 12'h000);
    check("t6_async_acc", acc1, 4'h0);
    check("t6_async_flags", {fc1, fz1}, 2'b00);
    step(1);
    check("t6_hold_pc", pa1, 12'h000);
    rst1 = 1'b0;
    step(1);
    check("t6_resume_pc", pa1, 12'h001);
    check("t6_resume_sel", sel1, 3'b010);
    step(1);
    check("t6_resume_acc", acc1, 4'h3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
